// File: rtl/link_align_ctrl.sv
// Word-alignment and link-training controller for a 10-bit deserialized receive path.
// Hunts for commas, slips the word boundary on timeout, verifies, locks and gates data downstream.
module link_align_ctrl #(
    parameter int          LOCK_COUNT   = 4,
    parameter int          HUNT_TIMEOUT = 16,
    parameter int          SLIP_WAIT    = 12,
    parameter int          ERR_LIMIT    = 4,
    parameter logic [9:0]  COMMA_P      = 10'b0011111100,
    parameter logic [9:0]  COMMA_N      = 10'b1100000011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [9:0]  word_in,
    input  logic        word_valid,
    output logic        bitslip,
    output logic        aligned,
    output logic [9:0]  word_out,
    output logic        word_out_valid,
    output logic [3:0]  slip_count,
    output logic [7:0]  err_count,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HUNT   = 3'd1,
        S_SLIP   = 3'd2,
        S_VERIFY = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    localparam logic [7:0] WORD_LAST  = 8'(HUNT_TIMEOUT - 1);
    localparam logic [3:0] COMMA_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [3:0] BAD_LAST   = 4'(ERR_LIMIT - 1);
    // The wait counter counts down to zero inclusive, so SLIP lasts exactly SLIP_WAIT cycles.
    localparam logic [7:0] WAIT_LOAD  = 8'(SLIP_WAIT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_word_cnt;
    logic [7:0]  w_word_cnt_next;
    logic [3:0]  r_comma_cnt;
    logic [3:0]  w_comma_cnt_next;
    logic [3:0]  r_bad_cnt;
    logic [3:0]  w_bad_cnt_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_next;

    logic        r_bitslip;
    logic [9:0]  r_word_out;
    logic        r_word_out_valid;
    logic [3:0]  r_slip_count;
    logic [7:0]  r_err_count;

    logic [3:0]  w_popcount;
    logic        w_is_comma;
    logic        w_code_err;
    logic        w_slip_req;
    logic        w_forward;
    logic        w_err_inc;

    always_comb begin
        w_popcount = 4'd0;
        for (int i = 0; i < 10; i++) begin
            w_popcount = w_popcount + {3'd0, word_in[i]};
        end
    end

    assign w_is_comma = (word_in == COMMA_P) || (word_in == COMMA_N);
    assign w_code_err = (w_popcount < 4'd4) || (w_popcount > 4'd6);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_word_cnt  <= 8'd0;
            r_comma_cnt <= 4'd0;
            r_bad_cnt   <= 4'd0;
            r_wait_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_word_cnt  <= w_word_cnt_next;
            r_comma_cnt <= w_comma_cnt_next;
            r_bad_cnt   <= w_bad_cnt_next;
            r_wait_cnt  <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_word_cnt_next  = r_word_cnt;
        w_comma_cnt_next = r_comma_cnt;
        w_bad_cnt_next   = r_bad_cnt;
        w_wait_cnt_next  = r_wait_cnt;
        w_slip_req       = 1'b0;
        w_forward        = 1'b0;
        w_err_inc        = 1'b0;

        if (!enable) begin
            w_state_next     = S_IDLE;
            w_word_cnt_next  = 8'd0;
            w_comma_cnt_next = 4'd0;
            w_bad_cnt_next   = 4'd0;
            w_wait_cnt_next  = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next    = S_HUNT;
                    w_word_cnt_next = 8'd0;
                end

                S_HUNT: begin
                    if (word_valid) begin
                        if (w_is_comma) begin
                            w_word_cnt_next = 8'd0;
                            if (COMMA_LAST == 4'd0) begin
                                w_state_next     = S_LOCKED;
                                w_comma_cnt_next = 4'd0;
                                w_bad_cnt_next   = 4'd0;
                            end else begin
                                w_state_next     = S_VERIFY;
                                w_comma_cnt_next = 4'd1;
                            end
                        end else if (r_word_cnt == WORD_LAST) begin
                            w_state_next    = S_SLIP;
                            w_slip_req      = 1'b1;
                            w_word_cnt_next = 8'd0;
                            w_wait_cnt_next = WAIT_LOAD;
                        end else begin
                            w_word_cnt_next = r_word_cnt + 8'd1;
                        end
                    end
                end

                S_SLIP: begin
                    if (r_wait_cnt == 8'd0) begin
                        w_state_next    = S_HUNT;
                        w_word_cnt_next = 8'd0;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt - 8'd1;
                    end
                end

                S_VERIFY: begin
                    if (word_valid) begin
                        if (w_code_err) begin
                            w_state_next     = S_SLIP;
                            w_slip_req       = 1'b1;
                            w_word_cnt_next  = 8'd0;
                            w_comma_cnt_next = 4'd0;
                            w_wait_cnt_next  = WAIT_LOAD;
                        end else if (w_is_comma) begin
                            w_word_cnt_next = 8'd0;
                            if (r_comma_cnt == COMMA_LAST) begin
                                w_state_next     = S_LOCKED;
                                w_comma_cnt_next = 4'd0;
                                w_bad_cnt_next   = 4'd0;
                            end else begin
                                w_comma_cnt_next = r_comma_cnt + 4'd1;
                            end
                        end else if (r_word_cnt == WORD_LAST) begin
                            w_state_next     = S_SLIP;
                            w_slip_req       = 1'b1;
                            w_word_cnt_next  = 8'd0;
                            w_comma_cnt_next = 4'd0;
                            w_wait_cnt_next  = WAIT_LOAD;
                        end else begin
                            w_word_cnt_next = r_word_cnt + 8'd1;
                        end
                    end
                end

                S_LOCKED: begin
                    if (word_valid) begin
                        if (w_code_err) begin
                            w_err_inc = 1'b1;
                            if (r_bad_cnt == BAD_LAST) begin
                                // The word that breaks lock is dropped rather than forwarded.
                                w_state_next    = S_HUNT;
                                w_word_cnt_next = 8'd0;
                                w_bad_cnt_next  = 4'd0;
                            end else begin
                                w_bad_cnt_next = r_bad_cnt + 4'd1;
                                w_forward      = 1'b1;
                            end
                        end else begin
                            w_bad_cnt_next = 4'd0;
                            w_forward      = 1'b1;
                        end
                    end
                end

                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitslip        <= 1'b0;
            r_word_out       <= 10'd0;
            r_word_out_valid <= 1'b0;
            r_slip_count     <= 4'd0;
            r_err_count      <= 8'd0;
        end else begin
            r_bitslip        <= w_slip_req;
            r_word_out_valid <= w_forward;
            if (word_valid) begin
                r_word_out <= word_in;
            end
            if (w_slip_req) begin
                r_slip_count <= (r_slip_count == 4'd9) ? 4'd0 : r_slip_count + 4'd1;
            end
            if (w_err_inc && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bitslip        = r_bitslip;
    assign aligned        = (r_state == S_LOCKED);
    assign word_out       = r_word_out;
    assign word_out_valid = r_word_out_valid;
    assign slip_count     = r_slip_count;
    assign err_count      = r_err_count;
    assign state_out      = r_state;

endmodule

// File: tb/tb_link_align_ctrl.sv
// Directed bench for link_align_ctrl: lock, slips, blanking, loss of lock, VERIFY error, enable/timeout races, reset.
module tb_link_align_ctrl;

    localparam logic [9:0] CP   = 10'b0011111100;
    localparam logic [9:0] DW   = 10'b0101010101;
    localparam logic [9:0] DW2  = 10'b0110011001;
    localparam logic [9:0] BAD  = 10'b1111111111;
    localparam logic [9:0] BAD1 = 10'b0000000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [9:0]  word_in;
    logic        word_valid;
    logic        bitslip;
    logic        aligned;
    logic [9:0]  word_out;
    logic        word_out_valid;
    logic [3:0]  slip_count;
    logic [7:0]  err_count;
    logic [2:0]  state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    link_align_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .bitslip        (bitslip),
        .aligned        (aligned),
        .word_out       (word_out),
        .word_out_valid (word_out_valid),
        .slip_count     (slip_count),
        .err_count      (err_count),
        .state_out      (state_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock, then settle just after the rising edge.
    task automatic drive(input logic en, input logic v, input logic [9:0] w);
        enable     = en;
        word_valid = v;
        word_in    = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; word_valid = 1'b0; word_in = 10'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_aligned", 32'(aligned), 32'd0);
        chk("rst_bitslip", 32'(bitslip), 32'd0);
        chk("rst_slip_count", 32'(slip_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_word_out", 32'(word_out), 32'd0);
        chk("rst_wov", 32'(word_out_valid), 32'd0);
        $display("reset released");
        rst = 1'b0;

        // Lock acquisition
        drive(1, 0, 10'd0);
        chk("lock_hunt", 32'(state_out), 32'd1);
        drive(1, 1, CP);
        chk("lock_verify1", 32'(state_out), 32'd3);
        drive(1, 1, DW);  drive(1, 1, CP);
        drive(1, 1, DW);  drive(1, 1, CP);
        drive(1, 1, DW);
        chk("lock_verify3", 32'(state_out), 32'd3);
        chk("lock_not_aligned_yet", 32'(aligned), 32'd0);
        drive(1, 1, CP);
        chk("lock_locked", 32'(state_out), 32'd4);
        chk("lock_aligned", 32'(aligned), 32'd1);
        chk("lock_no_slip", 32'(slip_count), 32'd0);
        chk("lock_bitslip", 32'(bitslip), 32'd0);
        $display("lock acquired: state=%0d aligned=%0b", state_out, aligned);

        // Forwarding in LOCKED
        drive(1, 1, DW2);
        chk("fwd_wov", 32'(word_out_valid), 32'd1);
        chk("fwd_word", 32'(word_out), 32'(DW2));
        drive(1, 0, 10'd0);
        chk("fwd_wov_idle", 32'(word_out_valid), 32'd0);
        chk("fwd_word_hold", 32'(word_out), 32'(DW2));
        $display("forwarded word %h", word_out);

        // Loss of lock: 3 errors, 1 good, 4 errors
        for (int i = 0; i < 3; i++) drive(1, 1, BAD);
        chk("lol_held", 32'(state_out), 32'd4);
        chk("lol_err3", 32'(err_count), 32'd3);
        chk("lol_err_fwd", 32'(word_out_valid), 32'd1);
        drive(1, 1, DW);
        chk("lol_good_held", 32'(aligned), 32'd1);
        for (int i = 0; i < 3; i++) drive(1, 1, BAD);
        chk("lol_held2", 32'(state_out), 32'd4);
        drive(1, 1, BAD);
        chk("lol_hunt", 32'(state_out), 32'd1);
        chk("lol_aligned", 32'(aligned), 32'd0);
        chk("lol_err7", 32'(err_count), 32'd7);
        chk("lol_dropped", 32'(word_out_valid), 32'd0);
        $display("lock lost: state=%0d err_count=%0d", state_out, err_count);

        // Hunt timeout with comma blanking in SLIP
        for (int i = 0; i < 15; i++) drive(1, 1, DW);
        chk("to_still_hunt", 32'(state_out), 32'd1);
        chk("to_no_slip_yet", 32'(bitslip), 32'd0);
        drive(1, 1, DW);
        chk("to_slip_state", 32'(state_out), 32'd2);
        chk("to_bitslip", 32'(bitslip), 32'd1);
        chk("to_slip_count1", 32'(slip_count), 32'd1);
        for (int i = 0; i < 11; i++) begin
            drive(1, 1, CP);
            chk("blank_state", 32'(state_out), 32'd2);
            chk("blank_bitslip", 32'(bitslip), 32'd0);
        end
        drive(1, 1, CP);
        chk("blank_back_hunt", 32'(state_out), 32'd1);
        $display("slip 1 done: slip_count=%0d", slip_count);

        // Nine more slips: slip_count wraps 9 -> 0
        for (int s = 2; s <= 10; s++) begin
            for (int i = 0; i < 16; i++) drive(1, 1, DW);
            chk("wrap_bitslip", 32'(bitslip), 32'd1);
            chk("wrap_slip_count", 32'(slip_count), 32'(s % 10));
            for (int i = 0; i < 12; i++) drive(1, 0, 10'd0);
            chk("wrap_back_hunt", 32'(state_out), 32'd1);
            $display("slip %0d done: slip_count=%0d", s, slip_count);
        end

        // VERIFY code error
        drive(1, 1, CP); drive(1, 1, CP);
        chk("verr_verify", 32'(state_out), 32'd3);
        drive(1, 1, BAD1);
        chk("verr_slip", 32'(state_out), 32'd2);
        chk("verr_bitslip", 32'(bitslip), 32'd1);
        chk("verr_slip_count", 32'(slip_count), 32'd1);
        for (int i = 0; i < 11; i++) drive(1, 0, 10'd0);
        chk("verr_still_slip", 32'(state_out), 32'd2);
        drive(1, 0, 10'd0);
        chk("verr_hunt", 32'(state_out), 32'd1);
        // comma_cnt was cleared: three commas keep VERIFY, fourth locks
        drive(1, 1, CP); drive(1, 1, CP); drive(1, 1, CP);
        chk("verr_cnt_cleared", 32'(state_out), 32'd3);
        drive(1, 1, CP);
        chk("verr_relock", 32'(state_out), 32'd4);
        $display("VERIFY error handled, relocked");

        // enable low from LOCKED keeps slip_count and err_count
        drive(0, 0, 10'd0);
        chk("en_idle", 32'(state_out), 32'd0);
        chk("en_err_kept", 32'(err_count), 32'd7);
        chk("en_slip_kept", 32'(slip_count), 32'd1);

        // enable falling on the timeout word: IDLE, no bitslip
        drive(1, 0, 10'd0);
        for (int i = 0; i < 15; i++) drive(1, 1, DW);
        drive(0, 1, DW);
        chk("race_idle", 32'(state_out), 32'd0);
        chk("race_no_bitslip", 32'(bitslip), 32'd0);
        chk("race_slip_count", 32'(slip_count), 32'd1);
        $display("enable/timeout race: state=%0d", state_out);

        // Comma on the timeout word: counts as comma, no slip
        drive(1, 0, 10'd0);
        for (int i = 0; i < 15; i++) drive(1, 1, DW);
        drive(1, 1, CP);
        chk("tocomma_verify", 32'(state_out), 32'd3);
        chk("tocomma_no_bitslip", 32'(bitslip), 32'd0);
        chk("tocomma_slip_count", 32'(slip_count), 32'd1);

        // Reset mid-LOCKED, with a valid error word present
        drive(1, 1, CP); drive(1, 1, CP); drive(1, 1, CP);
        chk("pre_rst_locked", 32'(state_out), 32'd4);
        rst = 1'b1;
        drive(1, 1, BAD);
        chk("mrst_state", 32'(state_out), 32'd0);
        chk("mrst_aligned", 32'(aligned), 32'd0);
        chk("mrst_err", 32'(err_count), 32'd0);
        chk("mrst_slip", 32'(slip_count), 32'd0);
        chk("mrst_bitslip", 32'(bitslip), 32'd0);
        chk("mrst_wov", 32'(word_out_valid), 32'd0);
        chk("mrst_word_out", 32'(word_out), 32'd0);
        rst = 1'b0;
        drive(1, 0, 10'd0);
        chk("post_rst_hunt", 32'(state_out), 32'd1);
        $display("mid-LOCKED reset done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
